// File: rtl/norz_pkg.sv
// Shared constants and types for the XOTR instruction-group sequencer.
package norz_pkg;

  localparam int XPT_W = 5;
  localparam int SRC_W = 8;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Phase-counter control; the counter applies clear > hold > inc.
  typedef struct packed {
    logic clear;
    logic hold;
    logic inc;
  } xpt_ctl_t;

endpackage

// File: rtl/xotr_phase_sequencer_xpt_counter.sv
// Phase timer with clear/hold/increment control, a registered complement output
// and a terminal-count flag. Shared by the instruction-group sequencers.
module xpt_counter
  import norz_pkg::*;
#(
  parameter int W = XPT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  xpt_ctl_t     ctl,
  output logic [W-1:0] xpt,
  output logic [W-1:0] not_xpt,
  output logic         tc
);

  logic [W-1:0] xpt_inc;

  assign xpt_inc = xpt + 1'b1;
  assign tc      = &xpt;

  // The complement is loaded on the same edge as the count, so it never lags.
  always_ff @(posedge clock) begin
    if (reset || ctl.clear) begin
      xpt     <= '0;
      not_xpt <= '1;
    end else if (ctl.hold) begin
      xpt     <= xpt;
      not_xpt <= not_xpt;
    end else if (ctl.inc) begin
      xpt     <= xpt_inc;
      not_xpt <= ~xpt_inc;
    end
  end

endmodule

// File: rtl/xotr_phase_sequencer.sv
// FETCH/EXEC sequencer for the XOTR opcode group: latches the opcode, runs XPT.
// Optional XOTR_WATCHDOG_EN forces a return to FETCH when XPT would wrap past 31.
module xotr_phase_sequencer #(
  parameter int XPT_W = 5,
  parameter int SRC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [SRC_W-1:0] op_byte,
  input  logic             is_xotr,
  input  logic             mem_wait,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Reset_XOTR,
  output logic             enable,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [SRC_W-1:0] Source,
  output logic [SRC_W-1:0] notSource,
  output logic             CM1,
  output logic             wdt_error
);
  import norz_pkg::*;

  state_t   state_q, state_d;
  xpt_ctl_t cnt_ctl;
  logic     src_ld;
  logic     wdt_fire;
  logic     xpt_tc;

  xpt_counter #(.W(XPT_W)) u_xpt (
    .clock   (clock),
    .reset   (reset),
    .ctl     (cnt_ctl),
    .xpt     (XPT),
    .not_xpt (notXPT),
    .tc      (xpt_tc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_ctl  = '0;
    src_ld   = 1'b0;
    wdt_fire = 1'b0;
    case (state_q)
      FETCH: begin
        cnt_ctl.clear = 1'b1;
        if (op_valid && is_xotr) begin
          src_ld  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (PR_Reset_XPT)  cnt_ctl.clear = 1'b1;
        else if (mem_wait) cnt_ctl.hold  = 1'b1;
        else begin
`ifdef XOTR_WATCHDOG_EN
          if (xpt_tc) begin
            wdt_fire      = 1'b1;
            cnt_ctl.clear = 1'b1;
            state_d       = FETCH;
          end else begin
            cnt_ctl.inc = 1'b1;
          end
`else
          cnt_ctl.inc = 1'b1;
`endif
        end
        // Either end pulse leaves EXEC; XPT returns to 0 so FETCH sees it cleared.
        if (P2_Set_CM1 || P2_Reset_XOTR) begin
          state_d       = FETCH;
          cnt_ctl.clear = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

`ifndef XOTR_WATCHDOG_EN
  logic unused_tc;
  assign unused_tc = xpt_tc;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      Source    <= '0;
      notSource <= '1;
      CM1       <= 1'b1;
      enable    <= 1'b0;
      wdt_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (src_ld) begin
        Source    <= op_byte;
        notSource <= ~op_byte;
      end
      CM1       <= (state_d == FETCH);
      enable    <= (state_d == EXEC);
      wdt_error <= wdt_fire;
    end
  end

endmodule

// File: tb/tb_xotr_phase_sequencer.sv
// Scoreboard bench for xotr_phase_sequencer; expectations follow XOTR_WATCHDOG_EN.
module tb_xotr_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       op_valid, is_xotr, mem_wait;
  logic       PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR;
  logic [7:0] op_byte;
  logic       enable, CM1, wdt_error;
  logic [4:0] XPT, notXPT;
  logic [7:0] Source, notSource;

  xotr_phase_sequencer #(.XPT_W(5), .SRC_W(8)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_byte(op_byte),
    .is_xotr(is_xotr), .mem_wait(mem_wait), .PR_Reset_XPT(PR_Reset_XPT),
    .P2_Set_CM1(P2_Set_CM1), .P2_Reset_XOTR(P2_Reset_XOTR), .enable(enable),
    .XPT(XPT), .notXPT(notXPT), .Source(Source), .notSource(notSource),
    .CM1(CM1), .wdt_error(wdt_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       en;
    logic       cm1;
    logic [4:0] xpt;
    logic [7:0] src;
    logic       wdt;
  } exp_t;

  // control word {reset, op_valid, is_xotr, mem_wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR}
  localparam logic [6:0] R = 7'h40, OV = 7'h20, IX = 7'h10, MW = 7'h08;
  localparam logic [6:0] PR = 7'h04, SC = 7'h02, RX = 7'h01, ENDP = 7'h07, NONE = 7'h00;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic exp_t mk(input logic en, input logic [4:0] x, input logic [7:0] s,
                              input logic w);
    exp_t e;
    e.en = en; e.cm1 = ~en; e.xpt = x; e.src = s; e.wdt = w;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic [6:0] ctl, input logic [7:0] ob, input exp_t e,
                      input string nm);
    @(negedge clock);
    {reset, op_valid, is_xotr, mem_wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR} = ctl;
    op_byte = ob;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  exp_t        m_e;
  string       m_nm;
  logic [27:0] m_act, m_want;

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_nm  = nm_q.pop_front();
      m_act  = {enable, CM1, XPT, notXPT, Source, notSource, wdt_error};
      m_want = {m_e.en, m_e.cm1, m_e.xpt, ~m_e.xpt, m_e.src, ~m_e.src, m_e.wdt};
      checks++;
      if (m_act !== m_want)
        $display("FAIL %s: got en=%b cm1=%b xpt=%h nxpt=%h src=%h nsrc=%h wdt=%b, want en=%b cm1=%b xpt=%h nxpt=%h src=%h nsrc=%h wdt=%b",
                 m_nm, enable, CM1, XPT, notXPT, Source, notSource, wdt_error,
                 m_e.en, m_e.cm1, m_e.xpt, ~m_e.xpt, m_e.src, ~m_e.src, m_e.wdt);
      else
        passed++;
    end
  end

  initial begin
    {reset, op_valid, is_xotr, mem_wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR} = R;
    op_byte = 8'h00;

    step(R,    8'h00, mk(0, 0, 8'h00, 0), "reset");
    step(R,    8'h00, mk(0, 0, 8'h00, 0), "reset_hold");
    step(NONE, 8'h00, mk(0, 0, 8'h00, 0), "fetch_idle");

    // ADC HL,BC ending at phase 10
    step(OV|IX, 8'h4A, mk(1, 0, 8'h4A, 0), "t1_entry");
    for (int k = 1; k <= 10; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h4A, 0), "t1_run");
    step(ENDP, 8'h00, mk(0, 0, 8'h4A, 0), "t1_end");
    step(NONE, 8'h00, mk(0, 0, 8'h4A, 0), "t1_fetch");

    // same instruction, three wait states at phase 4
    step(OV|IX, 8'h4A, mk(1, 0, 8'h4A, 0), "t2_entry");
    for (int k = 1; k <= 4; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h4A, 0), "t2_run_a");
    for (int k = 0; k < 3; k++)  step(MW,   8'h00, mk(1, 5'd4, 8'h4A, 0), "t2_wait");
    for (int k = 5; k <= 10; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h4A, 0), "t2_run_b");
    step(ENDP, 8'h00, mk(0, 0, 8'h4A, 0), "t2_end");

    // non-XOTR byte and decoder pulses in FETCH are ignored
    step(OV,      8'h42, mk(0, 0, 8'h4A, 0), "t3_not_xotr");
    step(PR|MW|SC, 8'h00, mk(0, 0, 8'h4A, 0), "t3_fetch_pulses");

    // clear beats wait at phase 7; lone P2_Set_CM1 exits
    step(OV|IX, 8'h61, mk(1, 0, 8'h61, 0), "t4_entry");
    for (int k = 1; k <= 7; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h61, 0), "t4_run");
    step(PR|MW, 8'h00, mk(1, 0, 8'h61, 0), "t4_clear_vs_wait");
    step(NONE,  8'h00, mk(1, 1, 8'h61, 0), "t4_after_clear");
    step(SC,    8'h00, mk(0, 0, 8'h61, 0), "t4_set_cm1");

    // op_valid ignored in EXEC; lone P2_Reset_XOTR exits keeping Source
    step(OV|IX, 8'h33, mk(1, 0, 8'h33, 0), "t5_entry");
    step(OV|IX, 8'hFF, mk(1, 1, 8'h33, 0), "t5_ov_in_exec");
    step(RX,    8'h00, mk(0, 0, 8'h33, 0), "t5_reset_xotr");

    // reset mid-instruction
    step(OV|IX, 8'h78, mk(1, 0, 8'h78, 0), "t6_entry");
    for (int k = 1; k <= 5; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h78, 0), "t6_run");
    step(R|OV|IX|MW, 8'h99, mk(0, 0, 8'h00, 0), "t6_reset");
    step(NONE, 8'h00, mk(0, 0, 8'h00, 0), "t6_after_reset");

    // run to phase 31 without an end pulse
    step(OV|IX, 8'h5A, mk(1, 0, 8'h5A, 0), "t7_entry");
    for (int k = 1; k <= 31; k++) step(NONE, 8'h00, mk(1, k[4:0], 8'h5A, 0), "t7_run");
    step(MW, 8'h00, mk(1, 5'd31, 8'h5A, 0), "t7_wait_at_31");
`ifdef XOTR_WATCHDOG_EN
    step(NONE, 8'h00, mk(0, 0, 8'h5A, 1), "t7_wdt_fire");
    step(NONE, 8'h00, mk(0, 0, 8'h5A, 0), "t7_wdt_single");
`else
    step(NONE, 8'h00, mk(1, 0, 8'h5A, 0), "t7_wrap");
    step(NONE, 8'h00, mk(1, 1, 8'h5A, 0), "t7_after_wrap");
    step(ENDP, 8'h00, mk(0, 0, 8'h5A, 0), "t7_end");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/xotr_phase_sequencer.md
# xotr_phase_sequencer

Sequences execution of the XOTR (extended-opcode) instruction group. Latches the opcode byte at the end of a fetch and runs the 5-bit phase timer XPT that the XOTR decoders consume. Honours memory wait states and returns the core to the fetch cycle when a decoder signals instruction end. Sits between the fetch unit and the DECODER_op_XOTR_* family, driving their enable, XPT/notXPT and Source/notSource inputs.

## Interface
Parameters:
- XPT_W, 5, phase timer width
- SRC_W, 8, opcode byte width

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  fetch unit presents a completed opcode byte this cycle
- op_byte  in  8  fetched opcode byte
- is_xotr  in  1  prefix logic marks op_byte as belonging to the XOTR group
- mem_wait  in  1  memory not ready; freezes XPT
- PR_Reset_XPT  in  1  decoder pulse: clear XPT
- P2_Set_CM1  in  1  decoder pulse: return to fetch
- P2_Reset_XOTR  in  1  decoder pulse: leave XOTR mode
- enable  out  1  XOTR decoders active
- XPT  out  5  phase timer
- notXPT  out  5  bitwise complement of XPT, registered alongside it
- Source  out  8  latched opcode byte
- notSource  out  8  bitwise complement of Source
- CM1  out  1  fetch-cycle request to the fetch unit
- wdt_error  out  1  one-cycle watchdog pulse (only with XOTR_WATCHDOG_EN)

## Operation
- States: FETCH, EXEC.
- FETCH:
  - CM1=1, enable=0, XPT held at 0.
  - op_valid=1 with is_xotr=1: latch Source=op_byte, go to EXEC.
  - op_valid=1 with is_xotr=0: ignored. The byte belongs to another group. Stay in FETCH.
- EXEC:
  - CM1=0, enable=1.
  - Each cycle, XPT increments by 1, unless mem_wait=1 (hold) or PR_Reset_XPT=1 (clear to 0).
- Priority in EXEC, highest first: reset, PR_Reset_XPT, mem_wait, increment.
- P2_Set_CM1=1 in EXEC: go to FETCH next cycle.
- P2_Reset_XOTR=1 in EXEC: enable drops next cycle even if P2_Set_CM1 is absent.
  - State goes to FETCH.
  - Source is retained.
- Decoders emit PR_Reset_XPT, P2_Set_CM1 and P2_Reset_XOTR together; coincident assertion is the normal end-of-instruction case.
- Wrap-around:
  - XPT=31 incrementing wraps to 0 when the macro is absent.
  - XPT=31 is handled by the watchdog when the macro is present.
- notXPT and notSource are always exact complements; they are never a cycle stale.
- Inputs other than reset are ignored in states where they have no meaning. Examples: PR_Reset_XPT in FETCH, op_valid in EXEC.

## Timing
- Reset values: state=FETCH, XPT=0, notXPT=5'h1F, Source=0, notSource=8'hFF, CM1=1, enable=0, wdt_error=0.
- Reset mid-instruction aborts to the reset values on the next edge; there is no drain.
- Latency from op_valid (FETCH, is_xotr=1) to enable=1 with XPT=0 and Source valid: 1 cycle.
- An instruction ending at phase N without waits occupies N+1 EXEC cycles. Each mem_wait cycle adds one.
- From end pulse to CM1=1 and enable=0: 1 cycle.
- All outputs are registered; none is combinational from inputs.

## Configuration
- XOTR_WATCHDOG_EN defined:
  - In EXEC with XPT=31 and no PR_Reset_XPT, the next edge forces FETCH with XPT=0.
  - wdt_error pulses for exactly one cycle on that edge.
  - mem_wait at XPT=31 holds and does not fire the watchdog.
- XOTR_WATCHDOG_EN absent:
  - wdt_error port is tied 0.
  - XPT wraps modulo 32.
  - There is no forced exit.

## Structure
- Shared package (norz_pkg):
  - XPT_W and SRC_W constants.
  - State enum with FETCH=0 and EXEC=1.
- Sub-module xpt_counter:
  - 5-bit counter with clear, hold and increment inputs, in that priority.
  - Drives registered XPT/notXPT outputs and a terminal-count flag at XPT=31.
  - Reusable by other instruction-group sequencers.

## Test plan
- Reset release, then op_valid=1, is_xotr=1, op_byte=8'h4A (ADC HL,BC); end pulses at XPT=10 -> Source=8'h4A, notSource=8'hB5, enable high for 11 cycles, CM1=1 on the cycle after the end pulse.
- Same instruction with mem_wait=1 for 3 cycles at XPT=4 -> XPT holds at 4 for 3 cycles; end occurs 14 cycles after entry.
- op_valid=1, is_xotr=0, op_byte=8'h42 -> state stays FETCH, Source unchanged, enable=0.
- PR_Reset_XPT and mem_wait together at XPT=7 -> XPT=0 next cycle.
- reset asserted at XPT=5 in EXEC -> next cycle XPT=0, enable=0, CM1=1, Source=0.
- With XOTR_WATCHDOG_EN, no end pulse -> at XPT=31 the next cycle gives FETCH, XPT=0, wdt_error high for exactly one cycle. Without the macro -> XPT wraps to 0, enable stays 1.
